mul_operand_feeder: RTL

- Streams buffered operand pairs into mul_3_stage_pipe_bf16 over its stb/ack input handshake, acting as the transmitting end of that interface.
- Counts the returned result strobes so a run can be checked for completion.
- Sits between the host/bench loader and the multiplier and replaces file-based stimulus in system-level runs.

---
 rtl/mul_operand_feeder_pkg.sv | 20 ++
 rtl/mul_operand_buf.sv | 28 ++
 rtl/mul_operand_feeder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mul_operand_feeder_pkg.sv
// Shared types and default sizing for the bf16 multiplier operand feeder.
// The multiplier and the system benches use the same defaults.
package mul_operand_feeder_pkg;

  localparam int DEFAULT_DW      = 16;
  localparam int DEFAULT_DEPTH   = 32;
  localparam int DEFAULT_AW      = 5;
  localparam int DEFAULT_TIMEOUT = 64;

  // Operand pair {a, b}: a in the upper half, b in the lower half.
  typedef logic [2*DEFAULT_DW-1:0] pair_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_operand_buf.sv
// Operand-pair store: one synchronous write port and one combinational read port.
// Contents survive reset so that a run can be replayed after an abort.
module mul_operand_buf
  import mul_operand_feeder_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data
);

  logic [2*DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/mul_operand_feeder.sv
// Streams buffered operand pairs into the bf16 multiplier over stb/ack and
// counts returned result strobes, flagging timeouts and excess results.
module mul_operand_feeder
  import mul_operand_feeder_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int AW      = DEFAULT_AW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            start,
  input  logic [AW:0]     len,
  output logic [2*DW-1:0] output_mul,
  output logic            output_mul_stb,
  input  logic            output_mul_ack,
  input  logic            z_stb,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [AW:0]     sent_cnt,
  output logic [AW:0]     recv_cnt
);

  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

  state_t          state_reg, state_next;
  logic [LW-1:0]   len_reg, len_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]   sent_reg, sent_next;
  logic [LW-1:0]   recv_reg, recv_next;
  logic            err_reg, err_next;
  logic [TW-1:0]   to_reg, to_next;
  logic [2*DW-1:0] rd_data;
  logic            buf_wr;
  logic            xfer;
  logic            z_count;

  // The buffer is frozen while a run is active, so the presented pair is
  // stable for as long as the multiplier withholds ack.
  assign buf_wr = wr_en && (state_reg == ST_IDLE || state_reg == ST_DONE);

  mul_operand_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  assign output_mul_stb = (state_reg == ST_SEND);
  assign output_mul     = output_mul_stb ? rd_data : '0;
  assign busy           = (state_reg == ST_SEND) || (state_reg == ST_DRAIN);
  assign done           = (state_reg == ST_DONE);
  assign error          = err_reg;
  assign sent_cnt       = sent_reg;
  assign recv_cnt       = recv_reg;

  assign xfer    = output_mul_stb && output_mul_ack;
  assign z_count = z_stb && busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      len_reg    <= '0;
      rd_ptr_reg <= '0;
      sent_reg   <= '0;
      recv_reg   <= '0;
      err_reg    <= 1'b0;
      to_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      len_reg    <= len_next;
      rd_ptr_reg <= rd_ptr_next;
      sent_reg   <= sent_next;
      recv_reg   <= recv_next;
      err_reg    <= err_next;
      to_reg     <= to_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    rd_ptr_next = rd_ptr_reg;
    sent_next   = sent_reg;
    recv_next   = recv_reg;
    err_next    = err_reg;
    to_next     = to_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          len_next    = (len > DEPTH_L) ? DEPTH_L : len;
          rd_ptr_next = '0;
          sent_next   = '0;
          recv_next   = '0;
          err_next    = 1'b0;
          to_next     = '0;
          state_next  = (len == '0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          sent_next   = sent_reg + 1'b1;
          rd_ptr_next = rd_ptr_reg + 1'b1;
          if (sent_reg + 1'b1 == len_reg) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        to_next = z_stb ? '0 : to_reg + 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    // Results may arrive while still sending; anything beyond len is an error.
    if (z_count) begin
      if (recv_reg == len_reg) begin
        err_next = 1'b1;
      end else begin
        recv_next = recv_reg + 1'b1;
      end
    end

    if (state_reg == ST_DRAIN) begin
      if (recv_next == len_reg) begin
        state_next = ST_DONE;
      end else if (!z_stb && (to_reg + 1'b1 == TIMEOUT_L)) begin
        state_next = ST_DONE;
        err_next   = 1'b1;
      end
    end
  end

endmodule
